// File: rtl/psram_pkg.sv
// ==========================================================================
// psram_pkg : shared states, command bytes and timing defaults for psram_ctrl
// Revision   : 1.0
// ==========================================================================
`default_nettype none

package psram_pkg;

  typedef enum logic [3:0] {
    INIT_WAIT,
    INIT_CMD,
    INIT_DESEL,
    IDLE,
    CMD1,
    CMD2,
    ADDR,
    WDATA,
    RWAIT,
    RDATA,
    DESEL
  } state_t;

  localparam logic [7:0] CMD_MODE = 8'h35;
  localparam logic [7:0] CMD_WR_1 = 8'h33;
  localparam logic [7:0] CMD_WR_2 = 8'h88;
  localparam logic [7:0] CMD_RD_1 = 8'hEE;
  localparam logic [7:0] CMD_RD_2 = 8'hBB;

  localparam int DEF_INIT_WAIT_CYC = 3;
  localparam int DEF_RD_WAIT_CYC   = 5;
  localparam int INIT_CMD_BITS     = 8;
  localparam int ADDR_NIBBLES      = 6;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // idx 5 selects addr[23:20], idx 0 selects addr[3:0]
  function automatic logic [3:0] addr_nibble(input logic [23:0] addr, input logic [2:0] idx);
    return addr[{idx, 2'b00} +: 4];
  endfunction

endpackage

`default_nettype wire

// File: rtl/psram_ctrl.sv
// ==========================================================================
// psram_ctrl : PSRAM controller, nibble address / byte data, registered bus.
//              Option macro PSRAM_CTRL_ALIGN_CHK_EN rejects odd addresses.
// Revision   : 1.0
// ==========================================================================
`default_nettype none

module psram_ctrl
  import psram_pkg::*;
#(
  parameter int INIT_WAIT_CYC = DEF_INIT_WAIT_CYC,
  parameter int RD_WAIT_CYC   = DEF_RD_WAIT_CYC
) (
  input  logic        psram_sclk,
  input  logic        arst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [23:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        init_done,
  output logic        psram_csn,
  output logic [7:0]  psram_dq_o,
  output logic        psram_dq_oe,
  input  logic [7:0]  psram_dq_i
);

  localparam int CNT_W = $clog2(max3(INIT_WAIT_CYC, RD_WAIT_CYC, INIT_CMD_BITS) + 1);
  localparam logic [CNT_W-1:0] INIT_WAIT_LAST = CNT_W'(INIT_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] RD_WAIT_LAST   = CNT_W'(RD_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] CMD_LAST       = CNT_W'(INIT_CMD_BITS - 1);
  localparam logic [CNT_W-1:0] ADDR_LAST      = CNT_W'(ADDR_NIBBLES - 1);
  localparam logic [CNT_W-1:0] DATA_LAST      = CNT_W'(1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [15:0]      sr, sr_n;
  logic [23:0]      addr, addr_n;
  logic             we, we_n;
  logic [15:0]      rdata_n;
  logic             done_n, valid_n;
  logic             csn_n, oe_n;
  logic [7:0]       dq_n;
  logic             err_n;

  assign req_ready = (state == IDLE) && init_done;

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    sr_n    = sr;
    addr_n  = addr;
    we_n    = we;
    rdata_n = rsp_rdata;
    done_n  = init_done;
    valid_n = 1'b0;
    err_n   = 1'b0;

    case (state)
      INIT_WAIT: begin
        if (cnt == INIT_WAIT_LAST) begin
          state_n = INIT_CMD;
          cnt_n   = '0;
          sr_n    = {CMD_MODE, 8'h00};
        end
      end
      INIT_CMD: begin
        sr_n = sr << 1;
        if (cnt == CMD_LAST) begin
          state_n = INIT_DESEL;
          done_n  = 1'b1;
        end
      end
      INIT_DESEL: state_n = IDLE;
      IDLE: begin
        cnt_n = '0;
        if (req_valid && req_ready) begin
          we_n   = req_we;
          addr_n = req_addr;
          sr_n   = req_wdata;
`ifdef PSRAM_CTRL_ALIGN_CHK_EN
          if (req_addr[0]) begin
            state_n = DESEL;
            valid_n = 1'b1;
            err_n   = 1'b1;
          end else begin
            state_n = CMD1;
          end
`else
          state_n = CMD1;
`endif
        end
      end
      CMD1: state_n = CMD2;
      CMD2: begin
        state_n = ADDR;
        cnt_n   = '0;
      end
      ADDR: begin
        if (cnt == ADDR_LAST) begin
          state_n = we ? WDATA : RWAIT;
          cnt_n   = '0;
        end
      end
      WDATA: begin
        if (cnt == DATA_LAST) begin
          state_n = DESEL;
          valid_n = 1'b1;
        end else begin
          sr_n = sr >> 8;
        end
      end
      RWAIT: begin
        if (cnt == RD_WAIT_LAST) begin
          state_n = RDATA;
          cnt_n   = '0;
        end
      end
      RDATA: begin
        if (cnt == '0) begin
          rdata_n[7:0] = psram_dq_i;
        end else begin
          rdata_n[15:8] = psram_dq_i;
          state_n       = DESEL;
          valid_n       = 1'b1;
        end
      end
      DESEL:   state_n = IDLE;
      default: state_n = INIT_WAIT;
    endcase

    // Bus values belong to the state being entered so they leave the flops with it.
    csn_n = 1'b1;
    oe_n  = 1'b0;
    dq_n  = '0;
    case (state_n)
      INIT_CMD: begin
        csn_n = 1'b0;
        oe_n  = 1'b1;
        dq_n  = {7'b0, sr_n[15]};
      end
      CMD1: begin
        csn_n = 1'b0;
        oe_n  = 1'b1;
        dq_n  = we_n ? CMD_WR_1 : CMD_RD_1;
      end
      CMD2: begin
        csn_n = 1'b0;
        oe_n  = 1'b1;
        dq_n  = we_n ? CMD_WR_2 : CMD_RD_2;
      end
      ADDR: begin
        csn_n = 1'b0;
        oe_n  = 1'b1;
        dq_n  = {4'b0, addr_nibble(addr_n, 3'(ADDR_LAST - cnt_n))};
      end
      WDATA: begin
        csn_n = 1'b0;
        oe_n  = 1'b1;
        dq_n  = sr_n[7:0];
      end
      RWAIT, RDATA: csn_n = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge psram_sclk or negedge arst_n) begin
    if (!arst_n) begin
      state       <= INIT_WAIT;
      cnt         <= '0;
      sr          <= '0;
      addr        <= '0;
      we          <= 1'b0;
      psram_csn   <= 1'b1;
      psram_dq_oe <= 1'b0;
      psram_dq_o  <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      init_done   <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      sr          <= sr_n;
      addr        <= addr_n;
      we          <= we_n;
      psram_csn   <= csn_n;
      psram_dq_oe <= oe_n;
      psram_dq_o  <= dq_n;
      rsp_valid   <= valid_n;
      rsp_rdata   <= rdata_n;
      init_done   <= done_n;
    end
  end

`ifdef PSRAM_CTRL_ALIGN_CHK_EN
  always_ff @(posedge psram_sclk or negedge arst_n) begin
    if (!arst_n) rsp_err <= 1'b0;
    else         rsp_err <= err_n;
  end
`else
  assign rsp_err = 1'b0;
  logic unused_err;
  assign unused_err = err_n;
`endif

endmodule

`default_nettype wire

// File: doc/psram_ctrl.md
PSRAM_CTRL -- requirements
Module: psram_ctrl

Interface
REQ-001 SHALL have parameter INIT_WAIT_CYC, default 3, cycles with csn high after reset before mode entry.
REQ-002 SHALL have parameter RD_WAIT_CYC, default 5, turnaround cycles between last address nibble and first read byte.
REQ-003 SHALL have port psram_sclk  input  1  clock; all logic on its rising edge.
REQ-004 SHALL have port arst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports req_valid input 1, req_ready output 1, req_we input 1, req_addr input 24, req_wdata input 16: request channel.
REQ-006 SHALL have ports rsp_valid output 1 (one-cycle pulse), rsp_rdata output 16, rsp_err output 1: response channel.
REQ-007 SHALL have port init_done output 1, high once mode entry has completed.
REQ-008 SHALL have ports psram_csn output 1, psram_dq_o output 8, psram_dq_oe output 1, psram_dq_i input 8: device bus; tristate buffering is done at top level.

Function
REQ-009 SHALL register every device-side output; the device samples on the same rising edge.
REQ-010 SHALL use states INIT_WAIT, INIT_CMD, INIT_DESEL, IDLE, CMD1, CMD2, ADDR, WDATA, RWAIT, RDATA, DESEL.
REQ-011 INIT_WAIT: csn=1, oe=0, for INIT_WAIT_CYC cycles -> INIT_CMD.
REQ-012 INIT_CMD: csn=0, oe=1, 8 cycles, dq_o[0] shifts 8'h35 MSB first, dq_o[7:1]=0 -> INIT_DESEL.
REQ-013 INIT_DESEL: csn=1, oe=0, 1 cycle -> IDLE; init_done set and held until reset.
REQ-014 IDLE: req_ready=1 only here, and only when init_done=1; handshake on req_valid&req_ready latches we/addr/wdata -> CMD1.
REQ-015 CMD1: csn=0, oe=1, dq_o=8'h33 (write) or 8'hEE (read); CMD2: dq_o=8'h88 (write) or 8'hBB (read).
REQ-016 ADDR: 6 cycles, dq_o[3:0]=addr[23:20] first down to addr[3:0] last, dq_o[7:4]=0.
REQ-017 Write: WDATA 2 cycles, dq_o=wdata[7:0] (to addr), then wdata[15:8] (to addr+1) -> DESEL; rsp_valid pulses in DESEL, rsp_rdata unchanged.
REQ-018 Read: RWAIT with oe=0, csn=0 for RD_WAIT_CYC cycles; RDATA 2 cycles captures dq_i into rsp_rdata[7:0] then [15:8] -> DESEL.
REQ-019 Read bytes SHALL be captured on the 6th and 7th rising edges after the edge that transfers addr[3:0] (default timing).
REQ-020 DESEL: csn=1, oe=0, exactly 1 cycle -> IDLE; rsp_valid=1 during DESEL for both reads and writes.
REQ-021 Device address addr+1 SHALL be formed modulo 2^24 (24'hFFFFFF -> 24'h000000); this wrap is the device's, not the controller's, responsibility.
REQ-022 Back-to-back: minimum two cycles csn high between transactions (DESEL + IDLE); request latency from handshake to rsp_valid: 11 cycles write, 16 cycles read.
REQ-023 req_valid during init or mid-transaction SHALL be held off by req_ready=0; no request is dropped.

Reset
REQ-024 On arst_n low: state INIT_WAIT, psram_csn=1, psram_dq_oe=0, psram_dq_o=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0.
REQ-025 Reset mid-transaction SHALL abort it with no rsp_valid and SHALL re-run the full init sequence after release.

Configuration
REQ-026 Macro PSRAM_CTRL_ALIGN_CHK_EN defined: a request with req_addr[0]=1 is accepted, no device cycle is issued, and rsp_valid and rsp_err pulse together on the next cycle.
REQ-027 Macro absent: odd addresses execute normally; rsp_err is tied to 0.

Structure
REQ-028 Package psram_pkg SHALL hold the state enum, the command bytes 8'h35/8'h33/8'h88/8'hEE/8'hBB, and the default timing constants.
REQ-029 No sub-module: a single FSM with one shared cycle counter and a 16-bit shift register.

Verification
REQ-030 Reset release -> csn high 3 cycles, 8'h35 serial on dq[0] over 8 cycles, init_done=1 on cycle 12.
REQ-031 Write addr 24'h000100, data 16'hBEEF -> bus shows 33,88,0,0,0,1,0,0,EF,BE; rsp_valid 11 cycles after handshake.
REQ-032 Read back 24'h000100 against the device model -> rsp_rdata=16'hBEEF, rsp_valid 16 cycles after handshake.
REQ-033 Write then read 24'hFFFFFF with 16'h1234 -> device bytes at FFFFFF=34, 000000=12; read returns 16'h1234.
REQ-034 arst_n pulsed during RWAIT -> csn=1 and oe=0 immediately, no rsp_valid, init re-runs.
REQ-035 With PSRAM_CTRL_ALIGN_CHK_EN, request at 24'h000003 -> csn stays high, rsp_valid and rsp_err pulse 1 cycle later.
